// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Holds the fetch PC and a single 128-bit line buffer, and presents pc/idata to the
// dual-issue fetch/select stage. On a miss it requests one line at a time over a
// req/gnt + rvalid handshake, with at most one request outstanding. Redirects that
// arrive while a request is in flight cause the returning line to be dropped.
// Optional build macro: FETCH_CTRL_PERF_EN adds perf_miss_cnt / perf_drop_cnt outputs.
module fetch_ctrl #(
  parameter int unsigned         ADDR_LEN  = 32,
  parameter int unsigned         LINE_BITS = 128,
  parameter logic [ADDR_LEN-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_LEN-1:0]  npc,
  input  logic                 stall_in,
  input  logic                 redirect,
  input  logic [ADDR_LEN-1:0]  redirect_pc,
  output logic [ADDR_LEN-1:0]  pc,
  output logic [LINE_BITS-1:0] idata,
  output logic                 fetch_valid,
  output logic                 imem_req,
  output logic [ADDR_LEN-1:0]  imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [LINE_BITS-1:0] imem_rdata
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_miss_cnt,
  output logic [31:0]          perf_drop_cnt
`endif
);

  localparam int unsigned TagW = ADDR_LEN - 4;

  typedef enum logic [1:0] {
    StRun,
    StReq,
    StWait,
    StDrop
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_LEN-1:0]  pc_q, pc_d;
  logic [ADDR_LEN-1:0]  req_addr_q, req_addr_d;
  logic [LINE_BITS-1:0] lbuf_q, lbuf_d;
  logic [TagW-1:0]      lbuf_tag_q, lbuf_tag_d;
  logic                 lbuf_valid_q, lbuf_valid_d;
  // Set when a redirect lands in REQ before the grant; the granted line is then stale.
  logic                 drop_pend_q, drop_pend_d;

  logic                 hit;
  logic                 consume;

  assign hit = lbuf_valid_q && (lbuf_tag_q == pc_q[ADDR_LEN-1:4]);

  // Next-state, PC update and handshake outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    lbuf_d       = lbuf_q;
    lbuf_tag_d   = lbuf_tag_q;
    lbuf_valid_d = lbuf_valid_q;
    drop_pend_d  = drop_pend_q;

    fetch_valid  = (state_q == StRun) && hit;
    imem_req     = (state_q == StReq);
    consume      = fetch_valid && !stall_in;

    // Redirect wins over consume; the pair shown this cycle is not taken.
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (consume) begin
      pc_d = npc;
    end

    case (state_q)
      StRun: begin
        if (!hit && !redirect) begin
          state_d     = StReq;
          req_addr_d  = {pc_q[ADDR_LEN-1:4], 4'b0000};
          drop_pend_d = 1'b0;
        end
      end
      StReq: begin
        // Address stays latched until granted; the request is never withdrawn.
        if (imem_gnt) begin
          state_d     = (drop_pend_q || redirect) ? StDrop : StWait;
          drop_pend_d = 1'b0;
        end else if (redirect) begin
          drop_pend_d = 1'b1;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          // A same-cycle redirect still installs the line under the old pc's tag.
          lbuf_d       = imem_rdata;
          lbuf_tag_d   = pc_q[ADDR_LEN-1:4];
          lbuf_valid_d = 1'b1;
          state_d      = StRun;
        end else if (redirect) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_rvalid) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      req_addr_q   <= '0;
      lbuf_q       <= '0;
      lbuf_tag_q   <= '0;
      lbuf_valid_q <= 1'b0;
      drop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      lbuf_q       <= lbuf_d;
      lbuf_tag_q   <= lbuf_tag_d;
      lbuf_valid_q <= lbuf_valid_d;
      drop_pend_q  <= drop_pend_d;
    end
  end

  assign pc        = pc_q;
  assign idata     = lbuf_q;
  assign imem_addr = req_addr_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Saturating counters: cycles spent off RUN, and entries into DROP.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if ((state_q != StRun) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
    if ((state_d == StDrop) && (state_q != StDrop) && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign perf_miss_cnt = miss_cnt_q;
  assign perf_drop_cnt = drop_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a transaction-level reference model.
module tb_fetch_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  npc = 32'h8;
  logic         stall_in = 1'b0;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic [31:0]  pc;
  logic [127:0] idata;
  logic         fetch_valid;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt = 1'b0;
  logic         imem_rvalid = 1'b0;
  logic [127:0] imem_rdata = '0;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0]  perf_miss_cnt;
  logic [31:0]  perf_drop_cnt;
`endif

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .npc         (npc),
    .stall_in    (stall_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .idata       (idata),
    .fetch_valid (fetch_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_miss_cnt (perf_miss_cnt),
    .perf_drop_cnt (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] LineA = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [127:0] LineB = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] LineC = 128'hCAFE_0003_CAFE_0002_CAFE_0001_CAFE_0000;
  localparam logic [127:0] Junk  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // Reference model: buffered line plus the life of the single memory transaction.
  logic [31:0]  m_pc;
  logic [31:0]  m_addr;
  logic [127:0] m_line;
  logic [27:0]  m_tag;
  bit           m_lvalid;
  bit           m_reqp;    // request shown, not yet granted
  bit           m_outst;   // granted, response pending
  bit           m_discard; // pending response belongs to an abandoned pc

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_addr    = 32'h0;
    m_line    = '0;
    m_tag     = '0;
    m_lvalid  = 1'b0;
    m_reqp    = 1'b0;
    m_outst   = 1'b0;
    m_discard = 1'b0;
  endtask

  function automatic bit m_hit();
    return m_lvalid && (m_tag == m_pc[31:4]);
  endfunction

  // Per-cycle comparison of every output against the model.
  task automatic compare_cycle();
    bit fv_e;
    fv_e = !m_reqp && !m_outst && m_hit();
    chk("fetch_valid", {127'b0, fetch_valid}, {127'b0, fv_e});
    chk("pc", {96'b0, pc}, {96'b0, m_pc});
    chk("imem_req", {127'b0, imem_req}, {127'b0, m_reqp});
    if (m_reqp) chk("imem_addr", {96'b0, imem_addr}, {96'b0, m_addr});
    if (!reset) chk("imem_addr_rst", {96'b0, imem_addr}, 128'h0);
    chk("idata", idata, m_line);
  endtask

  task automatic model_update();
    bit fv;
    if (!reset) begin
      model_reset();
      return;
    end
    fv = !m_reqp && !m_outst && m_hit();
    if (!m_reqp && !m_outst) begin
      if (!m_hit() && !redirect) begin
        m_reqp    = 1'b1;
        m_addr    = {m_pc[31:4], 4'h0};
        m_discard = 1'b0;
      end
    end else if (m_reqp) begin
      if (redirect) m_discard = 1'b1;
      if (imem_gnt) begin
        m_reqp  = 1'b0;
        m_outst = 1'b1;
      end
    end else begin
      if (imem_rvalid) begin
        if (!m_discard) begin
          m_line   = imem_rdata;
          m_tag    = m_pc[31:4];
          m_lvalid = 1'b1;
        end
        m_outst   = 1'b0;
        m_discard = 1'b0;
      end else if (redirect) begin
        m_discard = 1'b1;
      end
    end
    if (redirect) m_pc = redirect_pc;
    else if (fv && !stall_in) m_pc = npc;
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    model_update();
    #1;
    npc = m_pc + 32'd8;
  endtask

  task automatic set_in(input bit g, input bit rv, input bit rd, input bit st,
                        input logic [31:0] rpc, input logic [127:0] data);
    imem_gnt    = g;
    imem_rvalid = rv;
    redirect    = rd;
    stall_in    = st;
    redirect_pc = rpc;
    imem_rdata  = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    set_in(0, 0, 0, 0, 32'h0, '0);
    repeat (2) step();
    chk("rst_pc", {96'b0, pc}, 128'h0);
    chk("rst_fv", {127'b0, fetch_valid}, 128'h0);
    chk("rst_req", {127'b0, imem_req}, 128'h0);
    chk("rst_idata", idata, 128'h0);
    reset = 1'b1;

    // Cold start: miss, request line 0, gnt at once, rvalid two cycles later.
    step();
    chk("cold_req", {127'b0, imem_req}, 128'h1);
    chk("cold_addr", {96'b0, imem_addr}, 128'h0);
    set_in(1, 0, 0, 0, 32'h0, '0);   step();
    set_in(0, 0, 0, 0, 32'h0, '0);   step();
    set_in(0, 1, 0, 0, 32'h0, LineA); step();
    chk("cold_fv", {127'b0, fetch_valid}, 128'h1);
    chk("cold_pc", {96'b0, pc}, 128'h0);
    chk("cold_idata", idata, LineA);
    set_in(0, 0, 0, 0, 32'h0, '0);   step();
    chk("stream_pc8", {96'b0, pc}, 128'h8);
    chk("stream_noreq", {127'b0, imem_req}, 128'h0);

    // Decode stall holds the pair for three cycles.
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", {96'b0, pc}, 128'h8);
      chk("stall_fv", {127'b0, fetch_valid}, 128'h1);
    end
    stall_in = 1'b0;
    step();
    chk("cross_pc", {96'b0, pc}, 128'h10);
    step();
    chk("miss_addr", {96'b0, imem_addr}, 128'h10);

    // Redirect while waiting: response dropped, line 0 kept.
    set_in(1, 0, 0, 0, 32'h0, '0);    step();
    set_in(0, 0, 1, 0, 32'h40, '0);   step();
    set_in(0, 1, 0, 0, 32'h0, Junk);  step();
    chk("drop_idata", idata, LineA);
    set_in(0, 0, 1, 0, 32'h4, '0);    step();
    chk("redir_hit_fv", {127'b0, fetch_valid}, 128'h1);
    chk("redir_hit_pc", {96'b0, pc}, 128'h4);

    // Redirect during REQ with grant held low two cycles.
    set_in(0, 0, 1, 1, 32'h20, '0);   step();
    set_in(0, 0, 0, 1, 32'h0, '0);    step();
    chk("req_addr20", {96'b0, imem_addr}, 128'h20);
    set_in(0, 0, 1, 1, 32'h60, '0);   step();
    set_in(0, 0, 0, 1, 32'h0, '0);    step();
    chk("req_hold_addr", {96'b0, imem_addr}, 128'h20);
    chk("req_hold_pc", {96'b0, pc}, 128'h60);
    set_in(1, 0, 0, 1, 32'h0, '0);    step();
    set_in(0, 0, 0, 1, 32'h0, '0);    step();
    set_in(0, 1, 0, 1, 32'h0, Junk);  step();
    set_in(0, 0, 0, 1, 32'h0, '0);    step();
    chk("req_addr60", {96'b0, imem_addr}, 128'h60);

    // rvalid and redirect together: line installed under the old tag.
    set_in(1, 0, 0, 1, 32'h0, '0);    step();
    set_in(0, 1, 1, 1, 32'h4, LineB); step();
    chk("same_idata", idata, LineB);
    chk("same_fv", {127'b0, fetch_valid}, 128'h0);
    set_in(0, 0, 0, 1, 32'h0, '0);    step();

    // Asynchronous reset in the middle of a request.
    reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_req", {127'b0, imem_req}, 128'h0);
    chk("midrst_idata", idata, 128'h0);
    step();
    reset = 1'b1;
    set_in(0, 1, 0, 0, 32'h0, LineB); step();
    chk("late_rvalid_idata", idata, 128'h0);
    set_in(1, 0, 0, 0, 32'h0, '0);    step();
    set_in(0, 1, 0, 0, 32'h0, LineC); step();
    chk("refill_idata", idata, LineC);
    set_in(0, 0, 0, 0, 32'h0, '0);    step();
    set_in(0, 0, 1, 0, 32'hC, '0);    step();
    chk("wrap_pc", {96'b0, pc}, 128'hC);
    chk("wrap_fv", {127'b0, fetch_valid}, 128'h1);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
